// File: rtl/hash_result_framer_if.sv
// hash_result_framer_if: result capture, byte stream and status signals of the framer
interface hash_result_framer_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic             res_valid;
  logic [1:0]       res_idx;
  logic [23:0]      res_bounty;
  logic [31:0]      res_nonce;
  logic             batch_fin;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [LW-1:0]    fifo_level;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic             drained;
  modport master (
    output res_valid, res_idx, res_bounty, res_nonce, batch_fin, tx_ready,
    input  tx_data, tx_valid, fifo_level, overflow, drop_cnt, drained
  );
  modport slave (
    input  res_valid, res_idx, res_bounty, res_nonce, batch_fin, tx_ready,
    output tx_data, tx_valid, fifo_level, overflow, drop_cnt, drained
  );
endinterface

// File: rtl/hash_result_framer.sv
// hash_result_framer: buffers miner results and serialises them as 9-byte frames
module hash_result_framer #(
  parameter int         DEPTH     = 4,
  parameter int         CNT_W     = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic clk,
  input logic reset,
  hash_result_framer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [57:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [57:0] frame;
  logic [3:0] byte_idx;
  logic [5:0] seq;
  logic fin_seen, overflow, drained;
  logic [CNT_W-1:0] drop_cnt;
  logic empty, full, hs, last, pop, push;
  logic [71:0] shifted;
  assign empty = level == '0;
  assign full = level == LW'(DEPTH);
  assign hs = state == SEND && bus.tx_ready;
  assign last = hs && byte_idx == 4'd8;
  // a record leaves the FIFO when its frame starts, so a full FIFO can still take a push on that cycle
  assign pop = !empty && (state == IDLE || last);
  assign push = bus.res_valid && (!full || pop);
  assign shifted = {SYNC_BYTE, frame[57:56], seq, frame[55:0]} << {byte_idx, 3'b000};
  // record storage, no reset needed since level gates every read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.res_idx, bus.res_bounty, bus.res_nonce};
  // state register together with FIFO bookkeeping, frame register and status
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      frame <= '0;
      byte_idx <= '0;
      seq <= '0;
      fin_seen <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      drained <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (pop) frame <= mem[rd_ptr];
      byte_idx <= pop ? 4'd0 : hs ? byte_idx + 4'd1 : byte_idx;
      if (last) seq <= seq + 6'd1;
      if (bus.batch_fin) fin_seen <= 1'b1;
      if (bus.res_valid && !push) overflow <= 1'b1;
      if (bus.res_valid && !push && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      drained <= fin_seen && empty && state == IDLE && !bus.res_valid;
    end
  // next state: start a frame whenever a record waits, leave SEND only when the last byte goes with nothing queued
  always_comb
    state_nx = state == IDLE ? (empty ? IDLE : SEND) : (last && empty ? IDLE : SEND);
  // outputs: current frame byte while sending, zero otherwise
  always_comb begin
    bus.tx_valid = state == SEND;
    bus.tx_data = state == SEND ? shifted[71:64] : 8'h00;
    bus.fifo_level = level;
    bus.overflow = overflow;
    bus.drop_cnt = drop_cnt;
    bus.drained = drained;
  end
endmodule

// File: tb/tb_hash_result_framer.sv
// tb_hash_result_framer: randomized scoreboard bench for hash_result_framer
module tb_hash_result_framer;
  bit clk = 0;
  logic reset = 1;
  int checks = 0;
  int fails = 0;
  byte unsigned exp_q[$];
  logic [5:0] seq_m = 0;
  bit stalled = 0;
  logic [7:0] held = 0;
  hash_result_framer_if #(.DEPTH(4), .CNT_W(8)) bus();
  hash_result_framer #(.DEPTH(4), .CNT_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // expected frame of an accepted record, in the order bytes must appear on the stream
  task automatic push_frame(input logic [1:0] i, input logic [23:0] b, input logic [31:0] n);
    exp_q.push_back(8'hA5);
    exp_q.push_back({i, seq_m});
    for (int k = 2; k >= 0; k--) exp_q.push_back(b[8*k +: 8]);
    for (int k = 3; k >= 0; k--) exp_q.push_back(n[8*k +: 8]);
    seq_m++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    bus.res_valid = 0;
    bus.batch_fin = 0;
  endtask
  task automatic issue(input logic [1:0] i, input logic [23:0] b, input logic [31:0] n, input bit acc);
    bus.res_valid = 1;
    bus.res_idx = i;
    bus.res_bounty = b;
    bus.res_nonce = n;
    if (acc) push_frame(i, b, n);
  endtask
  // monitor: every accepted byte is compared with the scoreboard, stalled bytes must hold
  always @(negedge clk) begin
    if (reset) stalled = 0;
    else begin
      if (stalled) begin
        check("stall_valid", bus.tx_valid, 1);
        check("stall_data", bus.tx_data, held);
      end
      if (!bus.tx_valid) check("idle_data_zero", bus.tx_data, 0);
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data);
        end else begin
          byte unsigned e;
          e = exp_q.pop_front();
          check("tx_byte", bus.tx_data, e);
        end
      end
      stalled = bus.tx_valid && !bus.tx_ready;
      held = bus.tx_data;
    end
  end
  initial begin
    int n;
    bus.res_valid = 0;
    bus.res_idx = 0;
    bus.res_bounty = 0;
    bus.res_nonce = 0;
    bus.batch_fin = 0;
    bus.tx_ready = 1;
    repeat (3) step();
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_drop_cnt", bus.drop_cnt, 0);
    check("rst_drained", bus.drained, 0);
    reset = 0;
    step();
    issue(2'd2, 24'h00ABCD, 32'h12345678, 1);
    step();
    check("lat_n1_valid", bus.tx_valid, 0);
    step();
    check("lat_n2_valid", bus.tx_valid, 1);
    check("lat_n2_sync", bus.tx_data, 8'hA5);
    repeat (8) step();
    check("frame_len_valid", bus.tx_valid, 1);
    step();
    check("frame_end_valid", bus.tx_valid, 0);
    check("frame1_done", exp_q.size(), 0);
    issue(2'd1, 24'($urandom), $urandom, 1);
    for (int k = 0; k < 40; k++) begin
      bus.tx_ready = (k % 3 == 0);
      step();
    end
    check("bp_done", exp_q.size(), 0);
    bus.tx_ready = 0;
    for (int i = 0; i < 6; i++) begin
      issue(2'(i), 24'($urandom), $urandom, i < 5);
      step();
    end
    check("burst_level", bus.fifo_level, 4);
    check("burst_drop_cnt", bus.drop_cnt, 1);
    check("burst_overflow", bus.overflow, 1);
    check("burst_head_sync", bus.tx_data, 8'hA5);
    bus.tx_ready = 1;
    repeat (8) step();
    check("full_pre_level", bus.fifo_level, 4);
    issue(2'd3, 24'($urandom), $urandom, 1);
    step();
    check("full_pushpop_level", bus.fifo_level, 4);
    check("full_pushpop_nodrop", bus.drop_cnt, 1);
    repeat (44) step();
    check("b2b_valid", bus.tx_valid, 1);
    step();
    check("b2b_end_valid", bus.tx_valid, 0);
    check("b2b_done", exp_q.size(), 0);
    bus.tx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      issue(2'(i), 24'($urandom), $urandom, 1);
      step();
    end
    check("rst_pre_level", bus.fifo_level, 2);
    bus.tx_ready = 1;
    repeat (4) step();
    reset = 1;
    step();
    check("midrst_valid", bus.tx_valid, 0);
    check("midrst_level", bus.fifo_level, 0);
    check("midrst_overflow", bus.overflow, 0);
    check("midrst_drop_cnt", bus.drop_cnt, 0);
    exp_q.delete();
    seq_m = 0;
    reset = 0;
    step();
    issue(2'd3, 24'($urandom), $urandom, 1);
    repeat (14) step();
    check("post_rst_frame", exp_q.size(), 0);
    n = 0;
    for (int c = 0; c < 20000 && n < 70; c++) begin
      bus.tx_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 2) == 0 && (exp_q.size() + 8) / 9 < 4) begin
        issue(2'($urandom), 24'($urandom), $urandom, 1);
        n++;
      end
      step();
    end
    check("rand_issued", n, 70);
    check("rand_drained_pre_fin", bus.drained, 0);
    bus.batch_fin = 1;
    step();
    bus.tx_ready = 1;
    for (int c = 0; c < 500 && !bus.drained; c++) step();
    check("drained", bus.drained, 1);
    check("drained_empty", exp_q.size(), 0);
    check("drained_level", bus.fifo_level, 0);
    check("rand_drop_cnt", bus.drop_cnt, 0);
    check("rand_overflow", bus.overflow, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
